// File: rtl/display_pkg.sv
// Shared types and 7-segment glyph constants for the result display back-end.
// Segment vectors are ordered g..a and are active-low.
package display_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    UPDATE
  } state_e;

  localparam int unsigned BCD_DIGITS = 3;

  localparam logic [6:0] SEG_BLANK  = 7'h7F;
  localparam logic [6:0] SEG_0      = 7'b1000000;
  localparam logic [6:0] SEG_1      = 7'b1111001;
  localparam logic [6:0] SEG_2      = 7'b0100100;
  localparam logic [6:0] SEG_3      = 7'b0110000;
  localparam logic [6:0] SEG_4      = 7'b0011001;
  localparam logic [6:0] SEG_5      = 7'b0010010;
  localparam logic [6:0] SEG_6      = 7'b0000010;
  localparam logic [6:0] SEG_7      = 7'b1111000;
  localparam logic [6:0] SEG_8      = 7'b0000000;
  localparam logic [6:0] SEG_9      = 7'b0010000;
  localparam logic       SEG_DP_OFF = 1'b1;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD digit to active-low 7-segment decoder with a blank override.
module seg7_decode
  import display_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      case (digit)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/result_display.sv
// Captures a result on load, converts it to BCD by sequential double-dabble and
// registers the decoded digits, overflow glyph and decimal points onto four displays.
module result_display
  import display_pkg::*;
#(
  parameter bit          BLANK_LZ = 1'b1,
  parameter int unsigned WIDTH    = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  input  logic             addSubOverflow,
  input  logic [1:0]       multdivOverflow,
  output logic [7:0]       hex0,
  output logic [7:0]       hex1,
  output logic [7:0]       hex2,
  output logic [7:0]       hex3,
  output logic             busy,
  output logic             done
);

  localparam int unsigned BcdW = 4 * BCD_DIGITS;
  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic [WIDTH-1:0]  bin_q;
  logic [BcdW-1:0]   bcd_q;
  logic              asov_q;
  logic [1:0]        mdov_q;

  logic [BcdW-1:0]       bcd_adj;
  logic [BcdW+WIDTH-1:0] shifted;
  logic [3:0]            nib;

  // One double-dabble step: correct every nibble >= 5, then shift the pair left.
  always_comb begin
    bcd_adj = '0;
    nib     = '0;
    for (int i = 0; i < int'(BCD_DIGITS); i++) begin
      nib = bcd_q[4*i +: 4];
      bcd_adj[4*i +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
    end
    shifted = {bcd_adj, bin_q} << 1;
  end

  logic [3:0] d_hund, d_tens, d_ones;
  logic       blank_hund, blank_tens;
  logic [6:0] seg_hund, seg_tens, seg_ones;

  assign d_hund     = bcd_q[11:8];
  assign d_tens     = bcd_q[7:4];
  assign d_ones     = bcd_q[3:0];
  assign blank_hund = BLANK_LZ && (d_hund == 4'd0);
  assign blank_tens = blank_hund && (d_tens == 4'd0);

  seg7_decode u_dec_hund (.digit(d_hund), .blank(blank_hund), .seg(seg_hund));
  seg7_decode u_dec_tens (.digit(d_tens), .blank(blank_tens), .seg(seg_tens));
  seg7_decode u_dec_ones (.digit(d_ones), .blank(1'b0),       .seg(seg_ones));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bin_q   <= '0;
      bcd_q   <= '0;
      asov_q  <= 1'b0;
      mdov_q  <= 2'b00;
      hex0    <= 8'hFF;
      hex1    <= 8'hFF;
      hex2    <= 8'hFF;
      hex3    <= 8'hFF;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (load) begin
            bin_q   <= value;
            asov_q  <= addSubOverflow;
            mdov_q  <= multdivOverflow;
            bcd_q   <= '0;
            cnt_q   <= '0;
            busy    <= 1'b1;
            state_q <= CONVERT;
          end
        end
        CONVERT: begin
          {bcd_q, bin_q} <= shifted;
          cnt_q          <= cnt_q + 1'b1;
          if (cnt_q == CntLast) state_q <= UPDATE;
        end
        UPDATE: begin
          hex0    <= {~mdov_q[0], seg_ones};
          hex1    <= {~mdov_q[1], seg_tens};
          hex2    <= {SEG_DP_OFF, seg_hund};
          hex3    <= {SEG_DP_OFF, asov_q ? SEG_0 : SEG_BLANK};
          busy    <= 1'b0;
          done    <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_result_display.sv
// Self-checking bench for result_display: directed corner cases plus a full value
// sweep with random flags, checked against a div/mod-10 reference model.
module tb_result_display;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       load = 1'b0;
  logic [7:0] value = '0;
  logic       addSubOverflow = 1'b0;
  logic [1:0] multdivOverflow = 2'b00;
  logic [7:0] hex0, hex1, hex2, hex3;
  logic       busy, done;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] shown = 32'hFFFF_FFFF;

  always #5 clk = ~clk;

  result_display #(.BLANK_LZ(1'b1), .WIDTH(8)) dut (
    .clk(clk), .reset_n(reset_n), .load(load), .value(value),
    .addSubOverflow(addSubOverflow), .multdivOverflow(multdivOverflow),
    .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .busy(busy), .done(done)
  );

  function automatic logic [6:0] glyph(input int d);
    logic [6:0] tbl [10];
    tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
            7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    return tbl[d];
  endfunction

  // Expected {hex3, hex2, hex1, hex0} from decimal arithmetic on the value.
  function automatic logic [31:0] model(input int v, input logic as_, input logic [1:0] md);
    int h, t, o;
    logic [7:0] e3, e2, e1, e0;
    h  = v / 100;
    t  = (v / 10) % 10;
    o  = v % 10;
    e2 = {1'b1, (h == 0) ? 7'h7F : glyph(h)};
    e1 = {~md[1], (h == 0 && t == 0) ? 7'h7F : glyph(t)};
    e0 = {~md[0], glyph(o)};
    e3 = {1'b1, as_ ? glyph(0) : 7'h7F};
    return {e3, e2, e1, e0};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // mode 0: plain; 1: stray load of 9 at cycle N+4; 2: load held for a retrigger.
  task automatic conv(input logic [7:0] v, input logic as_, input logic [1:0] md,
                      input int mode);
    logic [31:0] exp;
    exp = model(int'(v), as_, md);
    @(negedge clk);
    load = 1'b1; value = v; addSubOverflow = as_; multdivOverflow = md;
    @(posedge clk);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (mode != 2) load = (mode == 1 && i == 4);
      if (mode == 1 && i == 4) begin
        value = 8'd9; addSubOverflow = ~as_; multdivOverflow = ~md;
      end
      check("busy", {31'd0, busy}, {31'd0, (i <= 9)});
      check("done", {31'd0, done}, {31'd0, (i == 10)});
      if (i < 10) check("hold", {hex3, hex2, hex1, hex0}, shown);
    end
    shown = exp;
    check("hex", {hex3, hex2, hex1, hex0}, exp);
    if (mode == 2) begin
      // Back in IDLE with load still high: a second conversion of the same operands.
      for (int i = 11; i <= 20; i++) begin
        @(negedge clk);
        if (i == 11) load = 1'b0;
        check("retrig_done", {31'd0, done}, {31'd0, (i == 20)});
      end
      check("retrig_hex", {hex3, hex2, hex1, hex0}, exp);
    end
    if (mode == 1) begin
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        check("single_done", {31'd0, done}, 32'd0);
      end
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_hex", {hex3, hex2, hex1, hex0}, 32'hFFFF_FFFF);
    check("rst_busy", {30'd0, busy, done}, 32'd0);
    reset_n = 1'b1;

    conv(8'd255, 1'b0, 2'b00, 0);
    check("v255", {hex3, hex2, hex1, hex0}, 32'hFF_A4_92_92);
    conv(8'd7, 1'b0, 2'b00, 0);
    check("v7", {hex3, hex2, hex1, hex0}, 32'hFF_FF_FF_F8);
    conv(8'd0, 1'b0, 2'b00, 0);
    check("v0", {hex3, hex2, hex1, hex0}, 32'hFF_FF_FF_C0);
    conv(8'd100, 1'b0, 2'b00, 0);
    check("v100", {hex3, hex2, hex1, hex0}, 32'hFF_F9_C0_C0);
    conv(8'd30, 1'b1, 2'b11, 0);
    check("v30_ovf", {hex3, hex2, hex1, hex0}, 32'hC0_FF_30_40);
    conv(8'd42, 1'b0, 2'b00, 1);
    check("v42_ign", {hex3, hex2, hex1, hex0}, 32'hFF_FF_99_A4);
    conv(8'd123, 1'b1, 2'b01, 2);

    // Reset in the middle of a conversion.
    @(negedge clk);
    load = 1'b1; value = 8'd99;
    @(posedge clk);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      load = 1'b0;
    end
    reset_n = 1'b0;
    #1;
    check("midrst_hex", {hex3, hex2, hex1, hex0}, 32'hFFFF_FFFF);
    check("midrst_busy", {30'd0, busy, done}, 32'd0);
    shown = 32'hFFFF_FFFF;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("midrst_nodone", {31'd0, done}, 32'd0);
    end
    reset_n = 1'b1;
    conv(8'd58, 1'b0, 2'b00, 0);
    check("v58", {hex3, hex2, hex1, hex0}, 32'hFF_FF_92_80);

    for (int v = 0; v < 256; v++) begin
      conv(8'(v), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/result_display.md
Name: result_display

Overview:
- Registered display back-end for the calculator datapath. Consumes the 8-bit arithmetic result and its overflow flags on a load strobe.
- Converts the unsigned result to three BCD digits with a sequential double-dabble (shift-add-3) engine.
- Drives four active-low 7-segment digits (HEX0..HEX3), including decimal points.
- Holds the last shown value stable until the next conversion completes.

Parameters:
- BLANK_LZ, 1, 1 = blank leading zeros on hundreds/tens; 0 = always show three digits
- WIDTH, 8, result width in bits; the BCD engine iterates WIDTH times (only 8 is supported/verified)

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- load  in  1  capture strobe; sampled high in IDLE starts a conversion
- value  in  8  unsigned result to display
- addSubOverflow  in  1  add/sub carry flag, captured with value
- multdivOverflow  in  2  mult/div flags, captured with value
- hex0  out  8  ones digit; [6:0]=g..a, [7]=dp, active-low
- hex1  out  8  tens digit, same encoding
- hex2  out  8  hundreds digit, same encoding
- hex3  out  8  overflow indicator digit
- busy  out  1  high while a conversion is in progress
- done  out  1  one-cycle pulse when new hex outputs first become visible

Behaviour:
- Interface: one clock (clk); reset_n is asynchronous and active-low.
- Reset (async assert, sync release): state=IDLE; hex0..hex3=8'hFF (all segments off); busy=0; done=0; all capture and shift registers cleared.
- FSM states: IDLE -> CONVERT -> UPDATE -> IDLE.
- IDLE:
  - On load=1 at edge N, capture value, addSubOverflow and multdivOverflow; clear the BCD register; go to CONVERT.
  - busy is high from cycle N+1.
- CONVERT (8 cycles, N+1..N+8):
  - Each cycle, add 3 to any BCD nibble >=5, then shift {bcd,bin} left by 1.
  - An iteration counter runs 0..7; exit to UPDATE after count 7.
- UPDATE (1 cycle):
  - Register the decoded segments into hex0..hex3.
  - busy drops and done=1 in the cycle new hex values first appear, 10 cycles after the load edge. Then return to IDLE.
- load while busy=1 is ignored: no queueing, and captured operands are not disturbed.
- load held high continuously retriggers a conversion on each return to IDLE.
- Digit encoding (bits g..a, active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000; blank=1111111.
- Leading-zero blanking (BLANK_LZ=1):
  - hundreds blank if 0;
  - tens blank if hundreds and tens are both 0;
  - ones is always shown (value 0 shows "0").
- Decimal points:
  - hex0[7]=~multdivOverflow[0] and hex1[7]=~multdivOverflow[1];
  - hex2[7]=1 and hex3[7]=1 always.
- hex3 shows the '0' glyph (read as 'O') when addSubOverflow=1, otherwise blank.
- Reset asserted mid-CONVERT: immediate return to reset values; no done pulse; the displays blank.
- Outputs change only in UPDATE; between conversions all hex outputs hold their values.

Decomposition:
- Package display_pkg:
  - state enum {IDLE, CONVERT, UPDATE};
  - SEG_BLANK=7'h7F;
  - the ten digit segment constants;
  - SEG_DP_OFF=1'b1.
- One sub-module, seg7_decode: combinational 4-bit BCD plus blank flag -> 7 segments, instantiated three times.

Test Plan:
- Reset, then pulse load with value=8'd255, flags 0 -> 10 cycles later done=1; hex2=8'hA4, hex1=8'h92, hex0=8'h92, hex3=8'hFF; busy=0.
- value=8'd7, BLANK_LZ=1 -> hex2=8'hFF, hex1=8'hFF, hex0=8'hF8; value=8'd0 -> hex0=8'hC0 and the others 8'hFF; value=8'd100 -> hex2=8'hF9, hex1=8'hC0, hex0=8'hC0.
- value=8'd30, addSubOverflow=1, multdivOverflow=2'b11 -> hex3=8'hC0, hex1=8'h30 (dp lit), hex0=8'h40 (dp lit).
- load=1 during cycle N+4 with value=8'd9 while converting 8'd42 -> only one done pulse; display shows 42 (hex1=8'h99, hex0=8'hA4); busy stays high throughout.
- Assert reset_n=0 at cycle N+5 of a conversion -> hex0..hex3=8'hFF immediately, busy=0, no done; a subsequent load of 8'd58 converts normally.
- Sweep all 256 values against a golden div/mod-10 model -> every digit and blanking pattern matches; done latency is exactly 10 cycles each time.
